eth_rx_dest_filter: RTL

//  Byte-wide AXIS stage between the RGMII MAC rx output and the rx frame buffer.

---
 rtl/eth_filter_pkg.sv | 34 +++
 rtl/eth_byte_fifo.sv | 55 +++++
 rtl/eth_rx_dest_filter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_filter_pkg.sv
// Shared types, constants and the destination-MAC match rule for eth_rx_dest_filter.
package eth_filter_pkg;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        ACCEPT = 2'd1,
        DROP   = 2'd2
    } filt_state_t;

    localparam logic [47:0] ETH_BCAST          = 48'hFFFF_FFFF_FFFF;
    localparam logic [23:0] ETH_IPV4_MCAST_OUI = 24'h01005E;
    localparam int          ETH_DMAC_BYTES     = 6;

    // One FIFO entry: the rx byte plus its framing sideband.
    typedef struct packed {
        logic       tuser;
        logic       tlast;
        logic [7:0] tdata;
    } rx_beat_t;

    localparam int RX_BEAT_W = $bits(rx_beat_t);

    function automatic logic dmac_match(
        input logic [47:0] dest,
        input logic [47:0] station,
        input logic        promisc
    );
        return promisc
            || (dest == ETH_BCAST)
            || (dest[47:24] == ETH_IPV4_MCAST_OUI)
            || (dest == station);
    endfunction

endpackage

// File: rtl/eth_byte_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with wrap-bit pointers; write while full is
// accepted only when a read frees a slot on the same cycle.
module eth_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_do_rd   = i_rd_en && !o_empty;
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_dest_filter.sv
// Destination-MAC filter between MAC rx and the frame buffer: buffers bytes,
// decides accept/drop on the 6th byte, forwards or discards whole frames.
// Optional statistics counters: define ETH_RX_FILTER_STATS_EN.
module eth_rx_dest_filter
    import eth_filter_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk_int,
    input  logic             rst_int,
    input  logic [47:0]      mac_address,
    input  logic             promiscuous,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             overflow,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [2:0] LAST_HDR_IDX = 3'(ETH_DMAC_BYTES - 1);

    filt_state_t r_state;
    logic [2:0]  r_idx;
    logic [39:0] r_dest;
    logic [47:0] w_dest;
    logic        w_match;
    logic        w_push;
    logic        w_push_val;

    rx_beat_t    w_wr_word;
    rx_beat_t    w_rd_word;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_rd_en;

    logic [3:0]  r_dq_mem;
    logic [2:0]  r_dq_wptr;
    logic [2:0]  r_dq_rptr;
    logic        w_dq_empty;
    logic        w_dq_full;
    logic        w_dq_head;
    logic        w_dq_push;
    logic        w_dq_pop;

    logic [7:0]  r_m_tdata;
    logic        r_m_tvalid;
    logic        r_m_tlast;
    logic        r_m_tuser;
    logic        r_overflow;

    // ------------------------------------------------------------------
    // Write side: header capture and per-frame decision
    // ------------------------------------------------------------------
    // The current byte completes the 48-bit destination when r_idx == 5.
    assign w_dest  = {r_dest, s_axis_tdata};
    assign w_match = dmac_match(w_dest, mac_address, promiscuous);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_push     = 1'b0;
        w_push_val = 1'b0;
        if (s_axis_tvalid && (r_state == HDR)) begin
            if (r_idx == LAST_HDR_IDX) begin
                w_push     = 1'b1;
                w_push_val = w_match;
            end else if (s_axis_tlast) begin
                w_push     = 1'b1;
                w_push_val = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            r_state <= HDR;
            r_idx   <= '0;
            r_dest  <= '0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
                r_idx <= '0;
            end else if (r_idx != 3'd7) begin
                r_idx <= r_idx + 3'd1;
            end

            case (r_state)
                HDR: begin
                    r_dest <= w_dest[39:0];
                    // A frame ending on its 6th byte is decided and finished at once.
                    if ((r_idx == LAST_HDR_IDX) && !s_axis_tlast) begin
                        r_state <= w_match ? ACCEPT : DROP;
                    end
                end
                ACCEPT, DROP: begin
                    if (s_axis_tlast) begin
                        r_state <= HDR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    assign w_wr_word = '{tuser: s_axis_tuser, tlast: s_axis_tlast, tdata: s_axis_tdata};

    eth_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RX_BEAT_W)
    ) u_fifo (
        .i_clk     (clk_int),
        .i_rst     (rst_int),
        .i_wr_en   (s_axis_tvalid),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_word),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Decision queue: one bit per frame, 1 = accept
    // ------------------------------------------------------------------
    assign w_dq_empty = (r_dq_wptr == r_dq_rptr);
    assign w_dq_full  = (r_dq_wptr[1:0] == r_dq_rptr[1:0]) && (r_dq_wptr[2] != r_dq_rptr[2]);
    assign w_dq_head  = r_dq_mem[r_dq_rptr[1:0]];
    assign w_dq_pop   = w_rd_en && w_rd_word.tlast;
    assign w_dq_push  = w_push && (!w_dq_full || w_dq_pop);

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            r_dq_mem  <= '0;
            r_dq_wptr <= '0;
            r_dq_rptr <= '0;
        end else begin
            if (w_dq_push) begin
                r_dq_mem[r_dq_wptr[1:0]] <= w_push_val;
                r_dq_wptr                <= r_dq_wptr + 3'd1;
            end
            if (w_dq_pop) begin
                r_dq_rptr <= r_dq_rptr + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: a byte leaves only once its frame has a decision
    // ------------------------------------------------------------------
    assign w_rd_en = !w_fifo_empty && !w_dq_empty;

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_m_tvalid <= w_rd_en && w_dq_head;
            r_m_tlast  <= w_rd_en && w_dq_head && w_rd_word.tlast;
            r_m_tuser  <= w_rd_en && w_dq_head && w_rd_word.tlast && w_rd_word.tuser;
            if (w_rd_en && w_dq_head) begin
                r_m_tdata <= w_rd_word.tdata;
            end
            if (s_axis_tvalid && w_fifo_full && !w_rd_en) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign overflow      = r_overflow;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef ETH_RX_FILTER_STATS_EN
    logic [CNT_W-1:0] r_accept_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    // Runts push a drop decision, so they land in drop_cnt.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
        end else if (w_dq_push) begin
            if (w_push_val) begin
                r_accept_cnt <= r_accept_cnt + 1'b1;
            end else begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign accept_cnt = r_accept_cnt;
    assign drop_cnt   = r_drop_cnt;
`else
    assign accept_cnt = '0;
    assign drop_cnt   = '0;
`endif

endmodule
